// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: arbiter ownership states, default memory geometry
// and a saturating counter helper used by the optional stall counter.
package mbist_pkg;

    localparam int MBIST_ADDR_W = 8;
    localparam int MBIST_DATA_W = 8;
    localparam int MBIST_RD_LAT = 1;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB_FUNC    = 2'd0,
        ARB_DRAIN   = 2'd1,
        ARB_BIST    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == STALL_CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mbist_rd_tracker.sv
// Read-valid shift register for functional reads issued to the SRAM port.
// o_in_flight is high while any issued read has not yet retired.
module mbist_rd_tracker #(
    parameter int RD_LAT = 1
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic i_issue,
    output logic o_rvalid,
    output logic o_in_flight
);

    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] w_shift_in;

    assign w_shift_in[0] = i_issue;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
            assign w_shift_in[gi] = r_valid[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_shift_in;
        end
    end

    assign o_rvalid    = r_valid[RD_LAT-1];
    assign o_in_flight = |r_valid;

endmodule

// File: rtl/mbist_mem_arbiter.sv
// Shares the single SRAM port between functional traffic and the MBIST engine.
// Optional macro ARB_STALL_CNT_EN adds a saturating STALL_CNT output.
module mbist_mem_arbiter
    import mbist_pkg::*;
#(
    parameter int ADDR_W = MBIST_ADDR_W,
    parameter int DATA_W = MBIST_DATA_W,
    parameter int RD_LAT = MBIST_RD_LAT
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              MBISTEN,
    output logic              BIST_ACK,
    input  logic              BIST_WRITE,
    input  logic              BIST_READ,
    input  logic [ADDR_W-1:0] BIST_ADDR,
    input  logic [DATA_W-1:0] BIST_DATA,
    output logic [DATA_W-1:0] BIST_RDATA,
    input  logic              FUNC_REQ,
    input  logic              FUNC_WE,
    input  logic [ADDR_W-1:0] FUNC_ADDR,
    input  logic [DATA_W-1:0] FUNC_WDATA,
    output logic              FUNC_GNT,
    output logic              FUNC_RVALID,
    output logic [DATA_W-1:0] FUNC_RDATA,
    output logic              MEM_WRITE,
    output logic              MEM_READ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]       STALL_CNT
`endif
);

    arb_state_e        r_state;
    logic              r_bist_ack;
    logic              r_mem_write;
    logic              r_mem_read;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_gnt;
    logic              w_rvalid;
    logic              w_in_flight;
    logic              w_drained;
    logic              w_bist_sel;

    // MBISTEN wins any tie; grant is also held low while reset is asserted.
    assign w_gnt     = nRESET & FUNC_REQ & (r_state == ARB_FUNC) & ~MBISTEN;
    assign w_drained = ~w_in_flight & ~r_mem_write & ~r_mem_read;
    assign w_bist_sel = (r_state == ARB_BIST);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= ARB_FUNC;
            r_bist_ack <= 1'b0;
        end else begin
            case (r_state)
                ARB_FUNC: begin
                    if (MBISTEN) begin
                        r_state <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (!MBISTEN) begin
                        r_state <= ARB_FUNC;
                    end else if (w_drained) begin
                        r_state    <= ARB_BIST;
                        r_bist_ack <= 1'b1;
                    end
                end
                ARB_BIST: begin
                    if (!MBISTEN) begin
                        r_state    <= ARB_RELEASE;
                        r_bist_ack <= 1'b0;
                    end
                end
                ARB_RELEASE: begin
                    r_state <= ARB_FUNC;
                end
                default: begin
                    r_state    <= ARB_FUNC;
                    r_bist_ack <= 1'b0;
                end
            endcase
        end
    end

    // Granted accesses are presented for exactly one cycle; address/data hold otherwise.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_write <= w_gnt & FUNC_WE;
            r_mem_read  <= w_gnt & ~FUNC_WE;
            if (w_gnt) begin
                r_mem_addr  <= FUNC_ADDR;
                r_mem_wdata <= FUNC_WDATA;
            end
        end
    end

    mbist_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .i_issue     (r_mem_read),
        .o_rvalid    (w_rvalid),
        .o_in_flight (w_in_flight)
    );

    // The BIST pass-through is selected by registered state only, so no input-to-select path.
    always_comb begin
        MEM_WRITE = r_mem_write;
        MEM_READ  = r_mem_read;
        MEM_ADDR  = r_mem_addr;
        MEM_WDATA = r_mem_wdata;
        if (w_bist_sel) begin
            MEM_WRITE = BIST_WRITE;
            MEM_READ  = BIST_READ;
            MEM_ADDR  = BIST_ADDR;
            MEM_WDATA = BIST_DATA;
        end
    end

    assign BIST_ACK    = r_bist_ack;
    assign BIST_RDATA  = MEM_RDATA;
    assign FUNC_GNT    = w_gnt;
    assign FUNC_RVALID = w_rvalid;
    assign FUNC_RDATA  = w_rvalid ? MEM_RDATA : '0;

`ifdef ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_stall_cnt <= 16'd0;
        end else if (FUNC_REQ && !w_gnt) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mbist_mem_arbiter.sv
// Bench for mbist_mem_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a cycle-indexed ownership/transaction model.
`timescale 1ns/1ps
module tb_mbist_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RL = 1;

    localparam int M_FUNC  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_BIST  = 2;
    localparam int M_REL   = 3;

    logic          CLK = 1'b0;
    logic          nRESET = 1'b0;
    logic          MBISTEN = 1'b0;
    logic          BIST_WRITE = 1'b0;
    logic          BIST_READ = 1'b0;
    logic [AW-1:0] BIST_ADDR = '0;
    logic [DW-1:0] BIST_DATA = '0;
    logic          FUNC_REQ = 1'b0;
    logic          FUNC_WE = 1'b0;
    logic [AW-1:0] FUNC_ADDR = '0;
    logic [DW-1:0] FUNC_WDATA = '0;

    logic          BIST_ACK;
    logic [DW-1:0] BIST_RDATA;
    logic          FUNC_GNT;
    logic          FUNC_RVALID;
    logic [DW-1:0] FUNC_RDATA;
    logic          MEM_WRITE;
    logic          MEM_READ;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]   STALL_CNT;
`endif

    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] tb_mem [2**AW] = '{default: '0};

    int n_cmp = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    mbist_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (RL)
    ) dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .MBISTEN     (MBISTEN),
        .BIST_ACK    (BIST_ACK),
        .BIST_WRITE  (BIST_WRITE),
        .BIST_READ   (BIST_READ),
        .BIST_ADDR   (BIST_ADDR),
        .BIST_DATA   (BIST_DATA),
        .BIST_RDATA  (BIST_RDATA),
        .FUNC_REQ    (FUNC_REQ),
        .FUNC_WE     (FUNC_WE),
        .FUNC_ADDR   (FUNC_ADDR),
        .FUNC_WDATA  (FUNC_WDATA),
        .FUNC_GNT    (FUNC_GNT),
        .FUNC_RVALID (FUNC_RVALID),
        .FUNC_RDATA  (FUNC_RDATA),
        .MEM_WRITE   (MEM_WRITE),
        .MEM_READ    (MEM_READ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_RDATA   (mem_rdata)
`ifdef ARB_STALL_CNT_EN
        ,
        .STALL_CNT   (STALL_CNT)
`endif
    );

    // SRAM with one cycle read latency
    always @(posedge CLK) begin
        if (MEM_WRITE) tb_mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_READ)  mem_rdata <= tb_mem[MEM_ADDR];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_func(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        FUNC_REQ   = 1'b1;
        FUNC_WE    = we;
        FUNC_ADDR  = a;
        FUNC_WDATA = d;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            func;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] m_mem [2**AW] = '{default: '0};
    int            m_mode = M_FUNC;
    int            cyc = 0;
    int            last_due = -1;
    logic          p_w = 1'b0, p_r = 1'b0;
    logic [AW-1:0] h_a = '0;
    logic [DW-1:0] h_d = '0;
    logic [15:0]   m_stall = 16'd0;

    initial begin
        logic          e_gnt, e_w, e_r, e_rv;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d, e_rd;
        forever begin
            @(negedge CLK);
            cyc++;
            chk("bist_rdata_pass", 32'(BIST_RDATA), 32'(mem_rdata));
            if (!nRESET) begin
                chk("m_rst_gnt",    32'(FUNC_GNT), 0);
                chk("m_rst_ack",    32'(BIST_ACK), 0);
                chk("m_rst_mwr",    32'(MEM_WRITE), 0);
                chk("m_rst_mrd",    32'(MEM_READ), 0);
                chk("m_rst_maddr",  32'(MEM_ADDR), 0);
                chk("m_rst_mwdata", 32'(MEM_WDATA), 0);
                chk("m_rst_rvalid", 32'(FUNC_RVALID), 0);
                chk("m_rst_rdata",  32'(FUNC_RDATA), 0);
`ifdef ARB_STALL_CNT_EN
                chk("m_rst_stall",  32'(STALL_CNT), 0);
                m_stall = 16'd0;
`endif
                m_mode   = M_FUNC;
                h_a      = '0;
                h_d      = '0;
                p_w      = 1'b0;
                p_r      = 1'b0;
                last_due = -1;
                rq.delete();
            end else begin
                e_gnt = FUNC_REQ && (m_mode == M_FUNC) && !MBISTEN;
                if (m_mode == M_BIST) begin
                    e_w = BIST_WRITE; e_r = BIST_READ; e_a = BIST_ADDR; e_d = BIST_DATA;
                end else begin
                    e_w = p_w; e_r = p_r; e_a = h_a; e_d = h_d;
                end
                e_rv = 1'b0;
                e_rd = '0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    if (rq[0].func) begin
                        e_rv = 1'b1;
                        e_rd = rq[0].data;
                    end else begin
                        chk("m_bist_rdata", 32'(BIST_RDATA), 32'(rq[0].data));
                    end
                    void'(rq.pop_front());
                end
                chk("m_gnt",    32'(FUNC_GNT), 32'(e_gnt));
                chk("m_ack",    32'(BIST_ACK), 32'(m_mode == M_BIST));
                chk("m_mwr",    32'(MEM_WRITE), 32'(e_w));
                chk("m_mrd",    32'(MEM_READ), 32'(e_r));
                chk("m_maddr",  32'(MEM_ADDR), 32'(e_a));
                chk("m_mwdata", 32'(MEM_WDATA), 32'(e_d));
                chk("m_rvalid", 32'(FUNC_RVALID), 32'(e_rv));
                chk("m_rdata",  32'(FUNC_RDATA), 32'(e_rd));
`ifdef ARB_STALL_CNT_EN
                chk("m_stall",  32'(STALL_CNT), 32'(m_stall));
                if (FUNC_REQ && !e_gnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
                if (e_r) begin
                    rq.push_back('{cyc + RL, m_mem[e_a], (m_mode != M_BIST)});
                    if (m_mode != M_BIST) last_due = cyc + RL;
                end
                if (e_w) m_mem[e_a] = e_d;
                p_w = e_gnt && FUNC_WE;
                p_r = e_gnt && !FUNC_WE;
                if (e_gnt) begin
                    h_a = FUNC_ADDR;
                    h_d = FUNC_WDATA;
                end
                case (m_mode)
                    M_FUNC:  if (MBISTEN) m_mode = M_DRAIN;
                    M_DRAIN: begin
                        if (!MBISTEN) m_mode = M_FUNC;
                        else if (last_due < cyc && !e_w && !e_r) m_mode = M_BIST;
                    end
                    M_BIST:  if (!MBISTEN) m_mode = M_REL;
                    default: m_mode = M_FUNC;
                endcase
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        nRESET   = 1'b0;
        FUNC_REQ = 1'b1;
        repeat (3) step();
        @(negedge CLK);
        chk("rst_gnt", 32'(FUNC_GNT), 0);
        chk("rst_ack", 32'(BIST_ACK), 0);
        chk("rst_mwr", 32'(MEM_WRITE), 0);
        step(); nRESET = 1'b1; FUNC_REQ = 1'b0;
        step();

        // functional write then read back
        step(); drive_func(1'b1, 8'h10, 8'hA5);
        @(negedge CLK); chk("wr_gnt", 32'(FUNC_GNT), 1);
        step(); FUNC_REQ = 1'b0;
        @(negedge CLK);
        chk("wr_mem_write", 32'(MEM_WRITE), 1);
        chk("wr_mem_addr",  32'(MEM_ADDR), 32'h10);
        chk("wr_mem_wdata", 32'(MEM_WDATA), 32'hA5);
        step();
        @(negedge CLK);
        chk("wr_strobe_1cyc", 32'(MEM_WRITE), 0);
        chk("wr_addr_held",   32'(MEM_ADDR), 32'h10);
        step(); drive_func(1'b0, 8'h10, 8'h00);
        @(negedge CLK); chk("rd_gnt", 32'(FUNC_GNT), 1);
        step(); FUNC_REQ = 1'b0;
        @(negedge CLK);
        chk("rd_mem_read",     32'(MEM_READ), 1);
        chk("rd_rvalid_early", 32'(FUNC_RVALID), 0);
        step();
        @(negedge CLK);
        chk("rd_rvalid", 32'(FUNC_RVALID), 1);
        chk("rd_rdata",  32'(FUNC_RDATA), 32'hA5);
        step();
        @(negedge CLK); chk("rd_rvalid_1cyc", 32'(FUNC_RVALID), 0);

        // drain behind an outstanding read
        step(); drive_func(1'b0, 8'h20, 8'h00);
        step(); FUNC_REQ = 1'b0; MBISTEN = 1'b1;
        @(negedge CLK);
        chk("dr_mem_read", 32'(MEM_READ), 1);
        chk("dr_ack_0a",   32'(BIST_ACK), 0);
        step(); FUNC_REQ = 1'b1;
        @(negedge CLK);
        chk("dr_rvalid", 32'(FUNC_RVALID), 1);
        chk("dr_ack_0b", 32'(BIST_ACK), 0);
        chk("dr_no_gnt", 32'(FUNC_GNT), 0);
        step();
        @(negedge CLK);
        chk("dr_ack_0c",  32'(BIST_ACK), 0);
        chk("dr_no_gnt2", 32'(FUNC_GNT), 0);
        step(); FUNC_REQ = 1'b0;
        @(negedge CLK); chk("dr_ack", 32'(BIST_ACK), 1);

        // BIST pass-through
        step(); BIST_WRITE = 1'b1; BIST_ADDR = 8'h3F; BIST_DATA = 8'h5A;
        @(negedge CLK);
        chk("bist_mem_write", 32'(MEM_WRITE), 1);
        chk("bist_mem_wdata", 32'(MEM_WDATA), 32'h5A);
        step(); BIST_WRITE = 1'b0; BIST_READ = 1'b1;
        @(negedge CLK);
        chk("bist_mem_read", 32'(MEM_READ), 1);
        chk("bist_mem_addr", 32'(MEM_ADDR), 32'h3F);
        step(); BIST_READ = 1'b0;
        @(negedge CLK);
        chk("bist_rdata",     32'(BIST_RDATA), 32'h5A);
        chk("bist_no_rvalid", 32'(FUNC_RVALID), 0);
        for (int i = 0; i < 5; i++) begin
            step(); drive_func(1'b1, 8'h44, 8'h77);
            @(negedge CLK); chk("bist_stall_gnt", 32'(FUNC_GNT), 0);
        end

        // release
        step(); MBISTEN = 1'b0;
        @(negedge CLK);
        chk("rel_ack_last", 32'(BIST_ACK), 1);
        chk("rel_gnt_0a",   32'(FUNC_GNT), 0);
        step(); BIST_WRITE = 1'b1;
        @(negedge CLK);
        chk("rel_ack",       32'(BIST_ACK), 0);
        chk("rel_mem_write", 32'(MEM_WRITE), 0);
        chk("rel_gnt_0b",    32'(FUNC_GNT), 0);
        step(); BIST_WRITE = 1'b0;
        @(negedge CLK); chk("rel_gnt_resume", 32'(FUNC_GNT), 1);
        step(); FUNC_REQ = 1'b0;
        @(negedge CLK);
        chk("rel_func_write", 32'(MEM_WRITE), 1);
        chk("rel_func_addr",  32'(MEM_ADDR), 32'h44);

        // tie: request and MBISTEN together
        step(); drive_func(1'b0, 8'h10, 8'h00); MBISTEN = 1'b1;
        @(negedge CLK); chk("tie_gnt", 32'(FUNC_GNT), 0);
        step(); FUNC_REQ = 1'b0; MBISTEN = 1'b0;
        @(negedge CLK);
        chk("tie_no_read",  32'(MEM_READ), 0);
        chk("tie_no_write", 32'(MEM_WRITE), 0);
        step(); step();

        // reset in the middle of a read
        step(); drive_func(1'b0, 8'h10, 8'h00);
        @(negedge CLK); chk("rm_gnt", 32'(FUNC_GNT), 1);
        step(); FUNC_REQ = 1'b0; nRESET = 1'b0;
        @(negedge CLK);
        chk("rm_mem_read", 32'(MEM_READ), 0);
        chk("rm_mem_addr", 32'(MEM_ADDR), 0);
        chk("rm_rvalid",   32'(FUNC_RVALID), 0);
        step(); nRESET = 1'b1;
        @(negedge CLK); chk("rm_rvalid_after", 32'(FUNC_RVALID), 0);
        step();
        @(negedge CLK); chk("rm_rvalid_after2", 32'(FUNC_RVALID), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            nRESET = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 29) == 0) MBISTEN = ~MBISTEN;
            FUNC_REQ   = ($urandom_range(0, 2) != 0);
            FUNC_WE    = 1'($urandom_range(0, 1));
            FUNC_ADDR  = AW'($urandom_range(0, 15));
            FUNC_WDATA = DW'($urandom);
            case ($urandom_range(0, 2))
                0: begin BIST_WRITE = 1'b0; BIST_READ = 1'b0; end
                1: begin BIST_WRITE = 1'b1; BIST_READ = 1'b0; end
                default: begin BIST_WRITE = 1'b0; BIST_READ = 1'b1; end
            endcase
            BIST_ADDR = AW'($urandom_range(0, 15));
            BIST_DATA = DW'($urandom);
        end
        step();
        nRESET = 1'b1; FUNC_REQ = 1'b0; BIST_WRITE = 1'b0; BIST_READ = 1'b0; MBISTEN = 1'b0;
        repeat (4) step();
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mbist_mem_arbiter.md
Name: mbist_mem_arbiter

Overview:
- Owns the single SRAM port `mem` and shares it between the functional requester and the MBIST engine `mbist_top`.
- Functional traffic gets a registered req/gnt path. MBIST gets a zero-latency pass-through once the port has drained.
- Sits between `mbist_top`, the system logic and `mem`, and sequences ownership from the MBISTEN level.

Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- RD_LAT, 1, mem read latency in cycles: oRdData valid RD_LAT cycles after the edge that samples iRead

Ports:
- CLK  in  1  clock
- nRESET  in  1  asynchronous active-low reset
- MBISTEN  in  1  MBIST ownership request (level)
- BIST_ACK  out  1  MBIST owns the memory port
- BIST_WRITE  in  1  MBIST write strobe
- BIST_READ  in  1  MBIST read strobe
- BIST_ADDR  in  ADDR_W  MBIST address
- BIST_DATA  in  DATA_W  MBIST write data
- BIST_RDATA  out  DATA_W  read data returned to MBIST
- FUNC_REQ  in  1  functional access request
- FUNC_WE  in  1  1 = write, 0 = read
- FUNC_ADDR  in  ADDR_W  functional address
- FUNC_WDATA  in  DATA_W  functional write data
- FUNC_GNT  out  1  request accepted this cycle
- FUNC_RVALID  out  1  functional read data valid
- FUNC_RDATA  out  DATA_W  functional read data
- MEM_WRITE  out  1  to mem iWrite
- MEM_READ  out  1  to mem iRead
- MEM_ADDR  out  ADDR_W  to mem iAddr
- MEM_WDATA  out  DATA_W  to mem iWrData
- MEM_RDATA  in  DATA_W  from mem oRdData

Behaviour:
- Reset: state FUNC, all registered outputs 0, read-valid pipeline cleared, BIST_ACK=0, FUNC_GNT=0 (combinational, forced 0 while nRESET low). Reset mid-operation aborts in-flight reads; no RVALID is produced for them.
- States:
  - FUNC: functional owner. MBISTEN=1 goes to DRAIN.
  - DRAIN: no grants. Goes to BIST when no read is in flight and no MEM_* strobe is pending. If MBISTEN drops before that, return to FUNC.
  - BIST: BIST_ACK=1. MBISTEN=0 goes to RELEASE.
  - RELEASE: MEM_WRITE=MEM_READ=0 for exactly one cycle, BIST_ACK=0, then FUNC. MBISTEN is ignored here; it is re-evaluated in FUNC.
- Grant: FUNC_GNT = FUNC_REQ & (state==FUNC) & !MBISTEN. MBISTEN wins any tie. Combinational; one access per granted cycle, back-to-back allowed.
- Accepted access is registered: MEM_* carry it for exactly one cycle after the grant edge. MEM_WRITE/MEM_READ are 0 in non-granted cycles, with address/data held.
- Functional read: FUNC_RVALID=1 and FUNC_RDATA=MEM_RDATA exactly RD_LAT cycles after the MEM_READ cycle, i.e. grant+1+RD_LAT.
  - Tracked by a valid shift register of depth RD_LAT.
  - FUNC_RDATA is combinational from MEM_RDATA, qualified by RVALID.
- BIST state:
  - MEM_* = BIST_* combinationally. The mux select is the registered state only.
  - BIST_RDATA = MEM_RDATA always.
  - Functional read pipeline is guaranteed empty.
- Outside BIST, BIST_* inputs are ignored.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- With it: output STALL_CNT[15:0], cleared by reset, +1 each cycle FUNC_REQ=1 & FUNC_GNT=0, saturating at 16'hFFFF.
- Without it: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package mbist_pkg holds:
  - state enum ARB_FUNC/ARB_DRAIN/ARB_BIST/ARB_RELEASE
  - default ADDR_W/DATA_W constants, reused by `mbist_top` and `mem`
- One natural sub-module: mbist_rd_tracker, the RD_LAT-deep valid shift register plus an in-flight flag used by the DRAIN exit condition.

Test Plan:
- Functional write then read:
  - FUNC write addr 8'h10 data 8'hA5: GNT same cycle, MEM_WRITE next cycle.
  - Read 8'h10: FUNC_RVALID at grant+2 (RD_LAT=1), FUNC_RDATA=8'hA5.
- Drain: read to 8'h20 granted, MBISTEN rises the next cycle. Required: state stays DRAIN until RVALID, then BIST_ACK=1. No FUNC_GNT while MBISTEN=1.
- Tie: FUNC_REQ and MBISTEN rise on the same edge. Required: FUNC_GNT=0 and no MEM strobe.
- BIST pass-through: full `mbist_top` Mscan run (TESTTYPE=0) through the arbiter gives the same RESULT as direct connection. BIST_READ at 8'h3F reaches MEM_READ in the same cycle.
- Release and reset:
  - MBISTEN 1→0: one cycle of MEM strobes at 0, BIST_ACK=0, grants resume the cycle after.
  - nRESET pulsed mid-read: no FUNC_RVALID, all outputs 0.
- With ARB_STALL_CNT_EN: FUNC_REQ held for 5 cycles during BIST gives STALL_CNT=5. Forcing 70000 stalled cycles gives STALL_CNT=16'hFFFF.
